// File: rtl/shared_reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shared_reg_file                                              |
// | Description : Multi-core register file, one write and two registered read  |
// |               ports per core, write-first bypass and collision arbitration.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module shared_reg_file #(
   parameter int NUM_CORES = 2,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 32,
   parameter int ZERO_REG  = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_CORES-1:0]                 we,
   input  logic [NUM_CORES*$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [NUM_CORES*DATA_W-1:0]          wr_data,
   input  logic [NUM_CORES-1:0]                 re,
   input  logic [NUM_CORES*$clog2(DEPTH)-1:0]   rd_addr_a,
   input  logic [NUM_CORES*$clog2(DEPTH)-1:0]   rd_addr_b,
   output logic [NUM_CORES*DATA_W-1:0]          rd_data_a,
   output logic [NUM_CORES*DATA_W-1:0]          rd_data_b,
   output logic [NUM_CORES-1:0]                 wr_conflict,
   output logic [15:0]                          conflict_cnt
);

   localparam int c_AW = $clog2(DEPTH);

   logic [c_AW-1:0]   w_wa   [NUM_CORES];
   logic [c_AW-1:0]   w_ra_a [NUM_CORES];
   logic [c_AW-1:0]   w_ra_b [NUM_CORES];
   logic [DATA_W-1:0] w_wd   [NUM_CORES];

   logic [NUM_CORES-1:0] w_wr_valid;
   logic [NUM_CORES-1:0] w_lose;
   logic [NUM_CORES-1:0] w_later;
   logic [NUM_CORES-1:0] w_head;
   logic [2:0]           w_col_cnt;
   logic [16:0]          w_cnt_sum;

   logic [DATA_W-1:0] r_mem      [DEPTH];
   logic [DATA_W-1:0] w_mem_next [DEPTH];
   logic [NUM_CORES-1:0] r_conf;
   logic [15:0]          r_cnt;

   generate
      for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
         assign w_wa[g]   = wr_addr[g*c_AW +: c_AW];
         assign w_ra_a[g] = rd_addr_a[g*c_AW +: c_AW];
         assign w_ra_b[g] = rd_addr_b[g*c_AW +: c_AW];
         assign w_wd[g]   = wr_data[g*DATA_W +: DATA_W];
      end
   endgenerate

   // Address-0 writes are dropped before arbitration when register 0 is hardwired.
   always_comb begin
      w_wr_valid = '0;
      for (int c = 0; c < NUM_CORES; c++)
         w_wr_valid[c] = we[c] && !((ZERO_REG != 0) && (w_wa[c] == '0));
   end

   // A core loses if a lower-indexed core writes the same address; the lowest
   // writer of a shared address marks one collision event.
   always_comb begin
      w_lose  = '0;
      w_later = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
         for (int j = 0; j < NUM_CORES; j++) begin
            if (w_wr_valid[c] && w_wr_valid[j] && (w_wa[c] == w_wa[j])) begin
               if (j < c)
                  w_lose[c] = 1'b1;
               else if (j > c)
                  w_later[c] = 1'b1;
            end
         end
      end
      w_head = w_later & ~w_lose;
   end

   always_comb begin
      w_col_cnt = '0;
      for (int c = 0; c < NUM_CORES; c++)
         if (w_head[c])
            w_col_cnt = w_col_cnt + 3'd1;
      w_cnt_sum = {1'b0, r_cnt} + {14'b0, w_col_cnt};
   end

   // Applied from the highest core down so the lowest index wins a shared address.
   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         w_mem_next[i] = r_mem[i];
      for (int c = NUM_CORES - 1; c >= 0; c--)
         if (w_wr_valid[c])
            w_mem_next[w_wa[c]] = w_wd[c];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= w_mem_next[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_conf <= '0;
         r_cnt  <= '0;
      end else begin
         r_conf <= w_lose;
         r_cnt  <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
      end
   end

   generate
      for (genvar g = 0; g < NUM_CORES; g++) begin : g_read
         logic [DATA_W-1:0] r_rd_a;
         logic [DATA_W-1:0] r_rd_b;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_rd_a <= '0;
               r_rd_b <= '0;
            end else if (re[g]) begin
               r_rd_a <= w_mem_next[w_ra_a[g]];
               r_rd_b <= w_mem_next[w_ra_b[g]];
            end
         end

         assign rd_data_a[g*DATA_W +: DATA_W] = r_rd_a;
         assign rd_data_b[g*DATA_W +: DATA_W] = r_rd_b;
      end
   endgenerate

   assign wr_conflict  = r_conf;
   assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/shared_reg_file.md
# shared_reg_file

Parametrised multi-port register file shared by the cores of the multicore processor, replacing the single-write, clock-level-sensitive register file. Each core gets one write port and two read ports. Reads are registered with a per-core read enable for stall hold, same-cycle writes are forwarded to reads, and simultaneous writes to one register are arbitrated and reported. It sits between each core's decode stage (read) and write-back stage (write).

## Interface
- NUM_CORES, 2, number of cores; each core has 1 write port and 2 read ports (A, B); range 1..4
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; power of two, at least 2
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- AW, $clog2(DEPTH), address width (derived, not overridden)
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- we  input  NUM_CORES  per-core write enable
- wr_addr  input  NUM_CORES*AW  per-core write address; core c uses bits [c*AW +: AW]
- wr_data  input  NUM_CORES*DATA_W  per-core write data
- re  input  NUM_CORES  per-core read enable; 0 holds that core's read outputs
- rd_addr_a, rd_addr_b  input  NUM_CORES*AW  per-core read addresses
- rd_data_a, rd_data_b  output  NUM_CORES*DATA_W  registered read data
- wr_conflict  output  NUM_CORES  registered pulse; bit c = core c lost a write collision last cycle
- conflict_cnt  output  16  saturating count of collision events since reset

## Operation
- Storage: DEPTH x DATA_W flops. Async reset (reset=0) clears every register, rd_data_a/b, wr_conflict and conflict_cnt to 0 immediately and holds them while low.
- Write: on a rising edge with we[c]=1, reg[wr_addr_c] <= wr_data_c. No level-sensitive or negative-edge behaviour.
- ZERO_REG=1: writes to address 0 are dropped, reads of address 0 return 0, and they take no part in collision detection.
- Collision: two or more cores with we=1 and the same effective address (not a dropped address-0 write) in one cycle. The lowest core index wins and its data is written. Every losing core gets wr_conflict[c]=1 on the next cycle. conflict_cnt increments by 1 per colliding address per cycle and saturates at 16'hFFFF. Non-colliding writes in the same cycle all complete.
- Read: on a rising edge with re[c]=1, rd_data_a_c <= value of reg[rd_addr_a_c] after this edge's writes (write-first bypass, using the arbitrated winner's data). The same applies to port B. With re[c]=0, that core's outputs hold.
- Any number of ports may read the same address. Reading and writing the same address in one cycle always returns the new data.
- Out-of-range addresses cannot occur (DEPTH is a power of two).

## Timing
- Write latency: data is stored at the edge where we=1 and is visible to any read sampled at that same edge.
- Read latency: 1 cycle. The address is presented in cycle N, and rd_data is valid after edge N+1 and holds until the next enabled read.
- wr_conflict: asserted for exactly one cycle, the cycle after the colliding edge; it is 0 otherwise.
- conflict_cnt: updates at the colliding edge plus 1 (same timing as wr_conflict).
- Reset deasserted mid-operation: the first edge with reset=1 performs normal writes and reads from the all-zero state. Reads pending at reset assertion are discarded and outputs are 0.
- No combinational path from inputs to outputs.

## Test plan
- Reset/readback: pulse reset low mid-cycle. Check that all outputs go 0 asynchronously. Then core0 writes 0xDEADBEEF to r5, reads r5 one cycle later and gets 0xDEADBEEF; core1 reads r5 and also gets 0xDEADBEEF.
- Bypass: in the same cycle core0 writes 0x12345678 to r7 and core1 reads r7 on port A with re=1. After that edge rd_data_a_1 = 0x12345678 (not the old value 0).
- Collision: both cores write r3 (core0 0xAAAA0000, core1 0x5555FFFF). r3 reads 0xAAAA0000, wr_conflict = 2'b10 for one cycle, and conflict_cnt = 1. Repeat with 0x10000 collisions and check conflict_cnt saturates at 0xFFFF.
- Zero register: both cores write r0 with 0xFFFFFFFF in the same cycle. Reads of r0 return 0, wr_conflict stays 0, and conflict_cnt is unchanged.
- Stall hold: core1 reads r9 (0x00000042) with re=1. Then re=0 for 3 cycles while core0 writes 0x99 to r9. rd_data_a_1 stays 0x42. On the next re=1 it shows 0x99.
- Parametrisation: NUM_CORES=4, DEPTH=64, DATA_W=64. Cores 0 and 2 write r63 while cores 1 and 3 write distinct registers. Core 0's data wins at r63, both distinct writes land, and wr_conflict = 4'b0100.
